// File: rtl/md5_sched.sv
// Run controller for the MD5 hash_op pipeline: feeds candidate blocks with the IV,
// finalises each digest, compares it to the target and captures the first match.
module md5_sched #(
    parameter int PIPE_LATENCY  = 384,
    parameter int CNT_W         = 32,
    parameter int STOP_ON_MATCH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [127:0]     target_hash,
    input  logic [511:0]     msg_in,
    input  logic             msg_valid,
    output logic             msg_ready,
    input  logic             msg_last,
    output logic             pipe_reset,
    output logic             pipe_en,
    output logic             pipe_valid_in,
    output logic [511:0]     pipe_m_in,
    output logic [31:0]      pipe_a,
    output logic [31:0]      pipe_b,
    output logic [31:0]      pipe_c,
    output logic [31:0]      pipe_d,
    input  logic             pipe_valid_out,
    input  logic [511:0]     pipe_m_out,
    input  logic [31:0]      pipe_a_out,
    input  logic [31:0]      pipe_b_out,
    input  logic [31:0]      pipe_c_out,
    input  logic [31:0]      pipe_d_out,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [511:0]     match_msg,
    output logic [CNT_W-1:0] hash_count
);
    // state | meaning
    // IDLE  | no run; waits for start
    // FEED  | accepting blocks into the pipeline
    // DRAIN | no new blocks; waits for in-flight results to be compared

    localparam int IFL_W = $clog2(PIPE_LATENCY + 2);
    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [1:0]         rst_sh_q;
    logic               pipe_valid_in_q;
    logic [511:0]       pipe_m_in_q;
    logic [IFL_W-1:0]   inflight_q, inflight_d;
    logic               fin_valid_q;
    logic [127:0]       fin_digest_q;
    logic [511:0]       fin_m_q;
    logic [127:0]       target_q;
    logic               done_q, found_q;
    logic [511:0]       match_msg_q;
    logic [CNT_W-1:0]   hash_count_q;

    logic accept, dec, cmp_hit, drain_empty, start_run, done_set;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign accept      = msg_valid && (state_q == S_FEED);
    assign dec         = pipe_valid_out && (inflight_q != '0);
    assign cmp_hit     = fin_valid_q && (fin_digest_q == target_q) && !found_q;
    // compare stage must be empty too, otherwise the last digest would be lost
    assign drain_empty = (inflight_q == '0) && !pipe_valid_in_q && !fin_valid_q;

    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        done_set  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FEED;
                    start_run = 1'b1;
                end
            end
            S_FEED: begin
                if ((accept && msg_last) || ((STOP_ON_MATCH != 0) && cmp_hit))
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_empty) begin
                    state_d  = S_IDLE;
                    done_set = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        if (accept && !dec)
            inflight_d = inflight_q + IFL_W'(1);
        else if (!accept && dec)
            inflight_d = inflight_q - IFL_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            rst_sh_q        <= 2'b00;
            pipe_valid_in_q <= 1'b0;
            pipe_m_in_q     <= '0;
            inflight_q      <= '0;
            fin_valid_q     <= 1'b0;
            fin_digest_q    <= '0;
            fin_m_q         <= '0;
            target_q        <= '0;
            done_q          <= 1'b0;
            found_q         <= 1'b0;
            match_msg_q     <= '0;
            hash_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            rst_sh_q        <= {rst_sh_q[0], 1'b1};
            pipe_valid_in_q <= accept;
            if (accept)
                pipe_m_in_q <= msg_in;
            fin_valid_q <= pipe_valid_out && (state_q != S_IDLE);
            if (pipe_valid_out) begin
                fin_digest_q <= {bswap32(pipe_a_out + IV_A), bswap32(pipe_b_out + IV_B),
                                 bswap32(pipe_c_out + IV_C), bswap32(pipe_d_out + IV_D)};
                fin_m_q      <= pipe_m_out;
            end
            if (start_run) begin
                target_q     <= target_hash;
                inflight_q   <= '0;
                done_q       <= 1'b0;
                found_q      <= 1'b0;
                match_msg_q  <= '0;
                hash_count_q <= '0;
            end else begin
                inflight_q <= inflight_d;
                if (fin_valid_q)
                    hash_count_q <= hash_count_q + CNT_W'(1);
                if (cmp_hit) begin
                    found_q     <= 1'b1;
                    match_msg_q <= fin_m_q;
                end
                if (done_set)
                    done_q <= 1'b1;
            end
        end
    end

    assign msg_ready     = (state_q == S_FEED);
    assign pipe_en       = (state_q != S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign pipe_reset    = ~rst_sh_q[1];
    assign pipe_valid_in = pipe_valid_in_q;
    assign pipe_m_in     = pipe_m_in_q;
    assign pipe_a        = IV_A;
    assign pipe_b        = IV_B;
    assign pipe_c        = IV_C;
    assign pipe_d        = IV_D;
    assign done          = done_q;
    assign found         = found_q;
    assign match_msg     = match_msg_q;
    assign hash_count    = hash_count_q;
endmodule

// File: tb/tb_md5_sched.sv
// Bench for md5_sched: behavioural delay-line pipeline whose output state inverts the
// finalise step for known blocks, plus an injection scoreboard on pipe_m_in.
module tb_md5_sched;
    localparam int PL  = 384;
    localparam int BUD = 2000;

    localparam logic [127:0] TGT_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam logic [127:0] TGT_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [511:0] EMPTY_BLK = {8'h80, 504'h0};
    localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 8'h18, 56'h0};
    localparam logic [511:0] ALT_BLK   = {8'h80, 496'h0, 8'h01};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [127:0] target_hash = '0;
    logic [511:0] msg_in = '0;
    logic msg_last = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0;
    logic msg_valid0 = 1'b0, msg_valid1 = 1'b0;

    logic msg_ready0, pipe_reset0, pipe_en0, pipe_valid_in0, busy0, done0, found0;
    logic msg_ready1, pipe_reset1, pipe_en1, pipe_valid_in1, busy1, done1, found1;
    logic [511:0] pipe_m_in0, match_msg0, pipe_m_in1, match_msg1;
    logic [31:0]  pa0, pb0, pc0, pd0, pa1, pb1, pc1, pd1;
    logic [31:0]  ao0, bo0, co0, do0, ao1, bo1, co1, do1;
    logic [31:0]  hash_count0, hash_count1;
    logic         pvo0, pvo1;
    logic [511:0] pmo0, pmo1;
    logic [512:0] pl0 [0:PL];
    logic [512:0] pl1 [0:PL];

    int n_cmp = 0;
    int n_err = 0;
    logic [511:0] sb_q [$];

    always #5 clk = ~clk;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [127:0] inv_state(input logic [127:0] t);
        return {bswap32(t[127:96]) - 32'h67452301, bswap32(t[95:64]) - 32'hefcdab89,
                bswap32(t[63:32])  - 32'h98badcfe, bswap32(t[31:0])  - 32'h10325476};
    endfunction

    // Known blocks yield the real pre-IV-add state; ALT_BLK fakes a collision with EMPTY.
    function automatic logic [127:0] pre_state(input logic [511:0] m);
        if (m == EMPTY_BLK || m == ALT_BLK) return inv_state(TGT_EMPTY);
        if (m == ABC_BLK) return inv_state(TGT_ABC);
        return m[127:0] ^ 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
    endfunction

    function automatic logic [511:0] filler(input int i);
        logic [31:0] w;
        w = (32'(i) * 32'h9e3779b9) ^ 32'h01234567;
        return {16{w}};
    endfunction

    always @(posedge clk) begin
        if (pipe_reset0) begin
            for (int k = 0; k <= PL; k++) pl0[k] <= '0;
        end else if (pipe_en0) begin
            for (int k = PL; k > 0; k--) pl0[k] <= pl0[k-1];
            pl0[0] <= {pipe_valid_in0, pipe_m_in0};
        end
        if (pipe_reset1) begin
            for (int k = 0; k <= PL; k++) pl1[k] <= '0;
        end else if (pipe_en1) begin
            for (int k = PL; k > 0; k--) pl1[k] <= pl1[k-1];
            pl1[0] <= {pipe_valid_in1, pipe_m_in1};
        end
    end

    assign pvo0 = pl0[PL][512];
    assign pmo0 = pl0[PL][511:0];
    assign {ao0, bo0, co0, do0} = pre_state(pmo0);
    assign pvo1 = pl1[PL][512];
    assign pmo1 = pl1[PL][511:0];
    assign {ao1, bo1, co1, do1} = pre_state(pmo1);

    md5_sched #(.PIPE_LATENCY(PL), .CNT_W(32), .STOP_ON_MATCH(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .target_hash(target_hash),
        .msg_in(msg_in), .msg_valid(msg_valid0), .msg_ready(msg_ready0), .msg_last(msg_last),
        .pipe_reset(pipe_reset0), .pipe_en(pipe_en0), .pipe_valid_in(pipe_valid_in0),
        .pipe_m_in(pipe_m_in0), .pipe_a(pa0), .pipe_b(pb0), .pipe_c(pc0), .pipe_d(pd0),
        .pipe_valid_out(pvo0), .pipe_m_out(pmo0), .pipe_a_out(ao0), .pipe_b_out(bo0),
        .pipe_c_out(co0), .pipe_d_out(do0), .busy(busy0), .done(done0), .found(found0),
        .match_msg(match_msg0), .hash_count(hash_count0));

    md5_sched #(.PIPE_LATENCY(PL), .CNT_W(32), .STOP_ON_MATCH(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .target_hash(target_hash),
        .msg_in(msg_in), .msg_valid(msg_valid1), .msg_ready(msg_ready1), .msg_last(msg_last),
        .pipe_reset(pipe_reset1), .pipe_en(pipe_en1), .pipe_valid_in(pipe_valid_in1),
        .pipe_m_in(pipe_m_in1), .pipe_a(pa1), .pipe_b(pb1), .pipe_c(pc1), .pipe_d(pd1),
        .pipe_valid_out(pvo1), .pipe_m_out(pmo1), .pipe_a_out(ao1), .pipe_b_out(bo1),
        .pipe_c_out(co1), .pipe_d_out(do1), .busy(busy1), .done(done1), .found(found1),
        .match_msg(match_msg1), .hash_count(hash_count1));

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on a handshake seen before the edge, pop when the injection appears.
    always @(negedge clk) begin
        if (!reset_n) begin
            sb_q.delete();
        end else begin
            if (pipe_valid_in0) begin
                if (sb_q.size() == 0) check("inject_unexpected", 512'(pipe_valid_in0), 512'(0));
                else check("inject_m", pipe_m_in0, sb_q.pop_front());
            end
            if (msg_valid0 && msg_ready0) sb_q.push_back(msg_in);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int which, input logic [127:0] tgt);
        target_hash = tgt;
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic send0(input logic [511:0] m, input logic last);
        logic ok;
        ok = 1'b0;
        msg_in = m;
        msg_last = last;
        msg_valid0 = 1'b1;
        for (int k = 0; k < BUD && !ok; k++) begin
            if (msg_ready0) ok = 1'b1;
            tick();
        end
        if (!ok) check("send0_ready", 512'(msg_ready0), 512'(1));
    endtask

    task automatic send1(input logic [511:0] m);
        logic ok;
        ok = 1'b0;
        msg_in = m;
        msg_last = 1'b0;
        msg_valid1 = 1'b1;
        for (int k = 0; k < BUD && !ok; k++) begin
            if (msg_ready1) ok = 1'b1;
            tick();
        end
        if (!ok) check("send1_ready", 512'(msg_ready1), 512'(1));
    endtask

    task automatic wait_done(input int which);
        for (int k = 0; k < BUD; k++) begin
            if ((which == 0) ? done0 : done1) break;
            tick();
        end
        check("done_wait", 512'((which == 0) ? done0 : done1), 512'(1));
    endtask

    initial begin
        int n_acc;
        int gaps;

        // reset values
        #1;
        check("rst_pipe_reset", 512'(pipe_reset0), 512'(1));
        check("rst_ready", 512'(msg_ready0), 512'(0));
        check("rst_en_busy", 512'({pipe_en0, busy0, done0, found0, pipe_valid_in0}), 512'(0));
        check("rst_m_in", pipe_m_in0, 512'(0));
        check("rst_match", match_msg0, 512'(0));
        check("rst_count", 512'(hash_count0), 512'(0));
        check("iv", 512'({pa0, pb0, pc0, pd0}), 512'(128'h67452301efcdab8998badcfe10325476));
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        check("pipe_reset_release", 512'(pipe_reset0), 512'(0));

        // empty-string block with latency boundary
        start_run(0, TGT_EMPTY);
        check("busy_after_start", 512'(busy0), 512'(1));
        send0(EMPTY_BLK, 1'b1);
        msg_valid0 = 1'b0;
        repeat (PL + 2) tick();
        check("empty_found_early", 512'(found0), 512'(0));
        tick();
        check("empty_found_on_time", 512'(found0), 512'(1));
        wait_done(0);
        check("empty_busy_fall", 512'(busy0), 512'(0));
        check("empty_match", match_msg0, EMPTY_BLK);
        check("empty_count", 512'(hash_count0), 512'(1));
        check("empty_found", 512'(found0), 512'(1));

        // "abc" as 3rd of 5 blocks, start pulsed mid-FEED with another target
        start_run(0, TGT_ABC);
        check("abc_cleared", 512'({done0, found0}), 512'(0));
        send0(filler(1), 1'b0);
        send0(filler(2), 1'b0);
        msg_valid0 = 1'b0;
        start_run(0, TGT_EMPTY);
        check("start_ignored_busy", 512'(busy0), 512'(1));
        send0(ABC_BLK, 1'b0);
        send0(EMPTY_BLK, 1'b0);
        send0(filler(5), 1'b1);
        msg_valid0 = 1'b0;
        wait_done(0);
        check("abc_count", 512'(hash_count0), 512'(5));
        check("abc_found", 512'(found0), 512'(1));
        check("abc_match", match_msg0, ABC_BLK);

        // two matches: first one is kept
        start_run(0, TGT_EMPTY);
        send0(filler(7), 1'b0);
        send0(ALT_BLK, 1'b0);
        send0(EMPTY_BLK, 1'b1);
        msg_valid0 = 1'b0;
        wait_done(0);
        check("two_match_msg", match_msg0, ALT_BLK);
        check("two_match_count", 512'(hash_count0), 512'(3));

        // 1000 back-to-back non-matching blocks
        start_run(0, TGT_EMPTY);
        for (int i = 0; i < 1000; i++) send0(filler(100 + i), (i == 999));
        msg_valid0 = 1'b0;
        wait_done(0);
        check("b2b_count", 512'(hash_count0), 512'(1000));
        check("b2b_found", 512'(found0), 512'(0));

        // random valid gaps
        start_run(0, TGT_ABC);
        for (int i = 0; i < 200; i++) begin
            gaps = int'($urandom_range(0, 3));
            if (gaps > 0) begin
                msg_valid0 = 1'b0;
                repeat (gaps) tick();
            end
            send0(filler(2000 + i), (i == 199));
        end
        msg_valid0 = 1'b0;
        wait_done(0);
        check("gaps_count", 512'(hash_count0), 512'(200));
        check("gaps_found", 512'(found0), 512'(0));
        check("gaps_sb_empty", 512'(sb_q.size()), 512'(0));

        // STOP_ON_MATCH = 1: ready drops on the edge the match is captured
        start_run(1, TGT_ABC);
        send1(filler(1));
        send1(filler(2));
        send1(ABC_BLK);
        n_acc = 0;
        msg_in = filler(3000);
        for (int k = 0; k < BUD; k++) begin
            if (!msg_ready1) break;
            msg_in = filler(3000 + n_acc);
            tick();
            n_acc++;
        end
        msg_valid1 = 1'b0;
        check("stop_ready_low", 512'(msg_ready1), 512'(0));
        check("stop_found", 512'(found1), 512'(1));
        check("stop_accepts_after", 512'(n_acc), 512'(PL + 3));
        wait_done(1);
        check("stop_count", 512'(hash_count1), 512'(3 + PL + 3));
        check("stop_match", match_msg1, ABC_BLK);

        // reset during DRAIN, then a fresh run
        start_run(0, TGT_EMPTY);
        send0(filler(9), 1'b0);
        send0(EMPTY_BLK, 1'b1);
        msg_valid0 = 1'b0;
        repeat (50) tick();
        check("drain_busy", 512'(busy0), 512'(1));
        reset_n = 1'b0;
        #1;
        check("mid_rst_flags", 512'({busy0, done0, found0, msg_ready0, pipe_en0, pipe_valid_in0}), 512'(0));
        check("mid_rst_pipe_reset", 512'(pipe_reset0), 512'(1));
        check("mid_rst_count", 512'(hash_count0), 512'(0));
        check("mid_rst_m_in", pipe_m_in0, 512'(0));
        tick(); tick();
        reset_n = 1'b1;
        repeat (3) tick();
        start_run(0, TGT_EMPTY);
        send0(filler(11), 1'b0);
        send0(EMPTY_BLK, 1'b1);
        msg_valid0 = 1'b0;
        wait_done(0);
        check("post_rst_count", 512'(hash_count0), 512'(2));
        check("post_rst_match", match_msg0, EMPTY_BLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
